// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants, state encodings and length helpers for the memory arbiter
package mem_arbiter_pkg;
  localparam int AddressWidth = 32;
  localparam int IDWidth = 1;
  localparam logic [2:0] LenByte = 3'd1;
  localparam logic [2:0] LenHalf = 3'd2;
  localparam logic [2:0] LenWord = 3'd4;
  typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;
  typedef enum logic {GRANT_IF, GRANT_LSB} grant_t;
  // Any length other than 1 or 2 bytes is serviced as a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    return (len == LenByte || len == LenHalf) ? len : LenWord;
  endfunction
endpackage

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: beat counter, next beat address, capture lane and completion flags
module mem_byte_sequencer
  import mem_arbiter_pkg::*;
#(
  parameter int AddrWidth = AddressWidth
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 start,
  input  logic [AddrWidth-1:0] base,
  input  logic [2:0]           len,
  output logic [AddrWidth-1:0] next_addr,
  output logic [1:0]           lane,
  output logic                 capture,
  output logic                 more,
  output logic                 done_rd,
  output logic                 done_wr
);
  logic [2:0]           cnt;
  logic [2:0]           len_q;
  logic [AddrWidth-1:0] base_q;
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt    <= 3'd0;
      len_q  <= LenWord;
      base_q <= '0;
    end else if (rdy_in) begin
      if (start) begin
        cnt    <= 3'd0;
        len_q  <= len;
        base_q <= base;
      end else if (cnt != 3'd7) begin
        cnt <= cnt + 3'd1;
      end
    end
  end
  // cnt counts edges since the grant; read data for beat k lands when cnt = k+1.
  always_comb begin
    next_addr = base_q + AddrWidth'(cnt) + AddrWidth'(1);
    lane      = cnt[1:0] - 2'd1;
    capture   = cnt != 3'd0 && cnt <= len_q;
    more      = ({1'b0, cnt} + 4'd1) < {1'b0, len_q};
    done_rd   = cnt == len_q;
    done_wr   = cnt == len_q - 3'd1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between instruction fetch and the load/store buffer
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AddrWidth = AddressWidth,
  parameter int DataWidth = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 rob_mem_rst_in,
  input  logic                 if_mem_en_in,
  input  logic [AddrWidth-1:0] if_mem_pc_in,
  output logic                 mem_if_valid_out,
  output logic [DataWidth-1:0] mem_if_inst_out,
  input  logic                 lsb_mem_en_in,
  input  logic                 lsb_mem_wr_in,
  input  logic [AddrWidth-1:0] lsb_mem_addr_in,
  input  logic [2:0]           lsb_mem_len_in,
  input  logic [DataWidth-1:0] lsb_mem_data_in,
  output logic                 mem_lsb_valid_out,
  output logic [DataWidth-1:0] mem_lsb_data_out,
  input  logic [7:0]           mem_din_in,
  output logic [7:0]           mem_dout_out,
  output logic [AddrWidth-1:0] mem_a_out,
  output logic                 mem_wr_out
);
  state_t               state, state_n;
  grant_t               last_grant;
  logic [DataWidth-1:0] buf_q, wdata_q, cap;
  logic [AddrWidth-1:0] seq_base, next_addr;
  logic [2:0]           seq_len;
  logic [1:0]           lane;
  logic                 capture, more, done_rd, done_wr;
  logic                 rd_state, aborting, finishing, free, if_ok, ls_ok, pick_if, start;

  mem_byte_sequencer #(.AddrWidth(AddrWidth)) u_seq (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .start     (start),
    .base      (seq_base),
    .len       (seq_len),
    .next_addr (next_addr),
    .lane      (lane),
    .capture   (capture),
    .more      (more),
    .done_rd   (done_rd),
    .done_wr   (done_wr)
  );

  // A completing requester is masked so its still-high level request is not re-served.
  always_comb begin
    rd_state  = state == IF_READ || state == LS_READ;
    aborting  = rd_state && rob_mem_rst_in;
    finishing = rd_state ? done_rd && !rob_mem_rst_in : state == LS_WRITE && done_wr;
    free      = state == IDLE || finishing || aborting;
    if_ok     = if_mem_en_in && !mem_if_valid_out && !(finishing && state == IF_READ);
    ls_ok     = lsb_mem_en_in && !mem_lsb_valid_out && !(finishing && state != IF_READ);
    pick_if   = if_ok && (!ls_ok || last_grant == GRANT_LSB);
    start     = free && !rob_mem_rst_in && (if_ok || ls_ok);
    state_n   = !free ? state : !start ? IDLE : pick_if ? IF_READ :
                lsb_mem_wr_in ? LS_WRITE : LS_READ;
    seq_base  = pick_if ? if_mem_pc_in : lsb_mem_addr_in;
    seq_len   = pick_if ? LenWord : norm_len(lsb_mem_len_in);
    cap       = (buf_q & ~(DataWidth'(8'hff) << {lane, 3'b000})) |
                (DataWidth'(mem_din_in) << {lane, 3'b000});
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state             <= IDLE;
      last_grant        <= GRANT_LSB;
      buf_q             <= '0;
      wdata_q           <= '0;
      mem_if_valid_out  <= 1'b0;
      mem_if_inst_out   <= '0;
      mem_lsb_valid_out <= 1'b0;
      mem_lsb_data_out  <= '0;
      mem_dout_out      <= 8'h00;
      mem_a_out         <= '0;
      mem_wr_out        <= 1'b0;
    end else if (rdy_in) begin
      state             <= state_n;
      mem_if_valid_out  <= finishing && state == IF_READ;
      mem_lsb_valid_out <= finishing && state != IF_READ;
      if (rd_state && capture) buf_q <= cap;
      if (finishing && state == IF_READ) mem_if_inst_out <= cap;
      if (finishing && state == LS_READ) mem_lsb_data_out <= cap;
      if (start) begin
        last_grant   <= pick_if ? GRANT_IF : GRANT_LSB;
        buf_q        <= '0;
        wdata_q      <= lsb_mem_data_in;
        mem_a_out    <= seq_base;
        mem_wr_out   <= !pick_if && lsb_mem_wr_in;
        mem_dout_out <= lsb_mem_data_in[7:0];
      end else if (!free && more) begin
        mem_a_out    <= next_addr;
        mem_dout_out <= 8'(wdata_q >> {lane + 2'd2, 3'b000});
      end else begin
        mem_wr_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a byte RAM model for the memory arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, rdy, flush;
  logic        if_en, if_valid, ls_en, ls_wr, ls_valid, wr;
  logic [31:0] if_pc, if_inst, ls_addr, ls_data, ls_dout, a;
  logic [2:0]  ls_len;
  logic [7:0]  din, dout;
  int          cyc = 0;
  int          vec = 0;
  int          errs = 0;
  logic [7:0]  ram [logic [31:0]];
  typedef struct {int at; bit chk; logic [31:0] d;} exp_t;
  exp_t q_if[$], q_ls[$], e_if, e_ls;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter dut (
    .clk_in            (clk),
    .rst_in            (rst_n),
    .rdy_in            (rdy),
    .rob_mem_rst_in    (flush),
    .if_mem_en_in      (if_en),
    .if_mem_pc_in      (if_pc),
    .mem_if_valid_out  (if_valid),
    .mem_if_inst_out   (if_inst),
    .lsb_mem_en_in     (ls_en),
    .lsb_mem_wr_in     (ls_wr),
    .lsb_mem_addr_in   (ls_addr),
    .lsb_mem_len_in    (ls_len),
    .lsb_mem_data_in   (ls_data),
    .mem_lsb_valid_out (ls_valid),
    .mem_lsb_data_out  (ls_dout),
    .mem_din_in        (din),
    .mem_dout_out      (dout),
    .mem_a_out         (a),
    .mem_wr_out        (wr)
  );

  function automatic logic [7:0] ram_rd(input logic [31:0] ad);
    return ram.exists(ad) ? ram[ad] : 8'h00;
  endfunction

  // Synchronous RAM: read data appears the cycle after its address.
  always @(posedge clk) begin
    din <= ram_rd(a);
    if (rdy && wr) ram[a] = dout;
  end

  // Scoreboard: completions are popped and checked for cycle and data.
  always @(negedge clk) begin
    if (if_valid) begin
      vec++;
      if (q_if.size() == 0) begin
        errs++;
        $display("FAIL if_unexpected: valid at cycle %0d, none required", cyc);
      end else begin
        e_if = q_if.pop_front();
        if (cyc !== e_if.at || (e_if.chk && if_inst !== e_if.d)) begin
          errs++;
          $display("FAIL if_complete: cycle %0d inst %h, required cycle %0d inst %h", cyc, if_inst, e_if.at, e_if.d);
        end
      end
    end
    if (ls_valid) begin
      vec++;
      if (q_ls.size() == 0) begin
        errs++;
        $display("FAIL lsb_unexpected: valid at cycle %0d, none required", cyc);
      end else begin
        e_ls = q_ls.pop_front();
        if (cyc !== e_ls.at || (e_ls.chk && ls_dout !== e_ls.d)) begin
          errs++;
          $display("FAIL lsb_complete: cycle %0d data %h, required cycle %0d data %h", cyc, ls_dout, e_ls.at, e_ls.d);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    if_en = 1'b0; if_pc = '0; ls_en = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_len = 3'd1; ls_data = '0;
    repeat (3) @(negedge clk);
    vec++;
    if ({if_valid, ls_valid, wr} !== 3'b000) begin
      errs++; $display("FAIL reset_ctrl: got %b required 000", {if_valid, ls_valid, wr});
    end
    vec++;
    if ({a, dout, if_inst, ls_dout} !== '0) begin
      errs++; $display("FAIL reset_data: a %h dout %h inst %h data %h required all 0", a, dout, if_inst, ls_dout);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_if_fetch();
    int c0, n;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    if_en = 1'b1; if_pc = 32'h100; c0 = cyc;
    q_if.push_back('{c0 + 6, 1'b1, 32'h0000_0013});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); n = cyc - c0;
      if (n >= 1 && n <= 4) begin
        vec++;
        if (a !== 32'h100 + 32'(n - 1)) begin
          errs++; $display("FAIL if_addr: cycle %0d got %h required %h", n, a, 32'h100 + 32'(n - 1));
        end
      end
      vec++;
      if (wr !== 1'b0) begin errs++; $display("FAIL if_wr: cycle %0d got %b required 0", n, wr); end
      if (if_valid) if_en = 1'b0;
    end
    vec++;
    if (q_if.size() != 0) begin errs++; $display("FAIL if_timeout: %0d pending required 0", q_if.size()); end
  endtask

  task automatic test_store();
    int c0, n;
    logic [31:0] d = 32'hDEADBEEF;
    ram[32'h1002] = 8'h55; ram[32'h1003] = 8'h66;
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h1000; ls_len = 3'd2; ls_data = d; c0 = cyc;
    q_ls.push_back('{c0 + 3, 1'b0, 32'h0});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); n = cyc - c0;
      if (n >= 1 && n <= 2) begin
        vec++;
        if ({wr, a, dout} !== {1'b1, 32'h1000 + 32'(n - 1), d[8*(n-1) +: 8]}) begin
          errs++; $display("FAIL store_beat: cycle %0d got wr %b a %h dout %h required 1 %h %h", n, wr, a, dout, 32'h1000 + 32'(n - 1), d[8*(n-1) +: 8]);
        end
      end
      if (n == 3) begin
        vec++;
        if (wr !== 1'b0) begin errs++; $display("FAIL store_wr_off: got %b required 0", wr); end
      end
      if (ls_valid) ls_en = 1'b0;
    end
    vec++;
    if ({ram_rd(32'h1000), ram_rd(32'h1001), ram_rd(32'h1002), ram_rd(32'h1003)} !== 32'hEFBE5566) begin
      errs++; $display("FAIL store_ram: got %h%h%h%h required efbe5566", ram_rd(32'h1000), ram_rd(32'h1001), ram_rd(32'h1002), ram_rd(32'h1003));
    end
    vec++;
    if (q_ls.size() != 0) begin errs++; $display("FAIL store_timeout: %0d pending required 0", q_ls.size()); end
  endtask

  task automatic test_round_robin();
    int c0, n;
    ram[32'h200] = 8'h78; ram[32'h201] = 8'h56; ram[32'h202] = 8'h34; ram[32'h203] = 8'h12;
    ram[32'h20] = 8'h80; ram[32'h21] = 8'hFF;
    if_en = 1'b1; if_pc = 32'h200;
    ls_en = 1'b1; ls_wr = 1'b0; ls_addr = 32'h20; ls_len = 3'd1; c0 = cyc;
    q_if.push_back('{c0 + 6, 1'b1, 32'h1234_5678});
    q_ls.push_back('{c0 + 8, 1'b1, 32'h0000_0080});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); n = cyc - c0;
      if (n == 1 || n == 6) begin
        vec++;
        if (a !== (n == 1 ? 32'h200 : 32'h20)) begin
          errs++; $display("FAIL rr_grant: cycle %0d got %h required %h", n, a, n == 1 ? 32'h200 : 32'h20);
        end
      end
      if (if_valid) if_en = 1'b0;
      if (ls_valid) ls_en = 1'b0;
    end
    vec++;
    if (q_if.size() + q_ls.size() != 0) begin errs++; $display("FAIL rr_timeout: %0d pending required 0", q_if.size() + q_ls.size()); end
  endtask

  task automatic test_flush_load();
    int c0, n;
    ram[32'h300] = 8'hAA; ram[32'h40] = 8'h11; ram[32'h41] = 8'h22;
    if_en = 1'b1; if_pc = 32'h300;
    ls_en = 1'b1; ls_wr = 1'b0; ls_addr = 32'h40; ls_len = 3'd2; c0 = cyc;
    q_ls.push_back('{c0 + 8, 1'b1, 32'h0000_2211});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); n = cyc - c0;
      if (n == 3) begin flush = 1'b1; if_en = 1'b0; end
      if (n == 4) begin
        flush = 1'b0;
        vec++;
        if (a === 32'h40 || wr !== 1'b0) begin
          errs++; $display("FAIL flush_no_grant: got a %h wr %b required a not 00000040 and wr 0", a, wr);
        end
      end
      if (n == 5) begin
        vec++;
        if (a !== 32'h40) begin errs++; $display("FAIL flush_next_grant: got %h required 00000040", a); end
      end
      if (ls_valid) ls_en = 1'b0;
    end
    vec++;
    if (q_ls.size() != 0) begin errs++; $display("FAIL flush_timeout: %0d pending required 0", q_ls.size()); end
  endtask

  task automatic test_flush_store();
    int c0, n;
    logic [31:0] d = 32'hCAFEF00D;
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h500; ls_len = 3'd4; ls_data = d; c0 = cyc;
    q_ls.push_back('{c0 + 5, 1'b0, 32'h0});
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); n = cyc - c0;
      if (n >= 1 && n <= 4) begin
        vec++;
        if ({wr, a, dout} !== {1'b1, 32'h500 + 32'(n - 1), d[8*(n-1) +: 8]}) begin
          errs++; $display("FAIL fstore_beat: cycle %0d got wr %b a %h dout %h required 1 %h %h", n, wr, a, dout, 32'h500 + 32'(n - 1), d[8*(n-1) +: 8]);
        end
      end
      if (n == 2) flush = 1'b1;
      if (n == 3) flush = 1'b0;
      if (ls_valid) ls_en = 1'b0;
    end
    vec++;
    if ({ram_rd(32'h500), ram_rd(32'h501), ram_rd(32'h502), ram_rd(32'h503)} !== 32'h0DF0FECA) begin
      errs++; $display("FAIL fstore_ram: got %h%h%h%h required 0df0feca", ram_rd(32'h500), ram_rd(32'h501), ram_rd(32'h502), ram_rd(32'h503));
    end
    vec++;
    if (q_ls.size() != 0) begin errs++; $display("FAIL fstore_timeout: %0d pending required 0", q_ls.size()); end
  endtask

  task automatic test_stall_reset();
    int c0, n;
    if_en = 1'b1; if_pc = 32'h100; c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); n = cyc - c0;
      if (n >= 2 && n <= 5) begin
        vec++;
        if ({a, wr, if_valid} !== {32'h101, 2'b00}) begin
          errs++; $display("FAIL stall_hold: cycle %0d got a %h wr %b valid %b required 00000101 0 0", n, a, wr, if_valid);
        end
      end
      if (n == 2) rdy = 1'b0;
      if (n == 5) rdy = 1'b1;
      if (n == 6) rst_n = 1'b0;
    end
    @(negedge clk);
    vec++;
    if ({if_valid, ls_valid, wr, a, if_inst, ls_dout} !== '0) begin
      errs++; $display("FAIL midreset: valid %b%b wr %b a %h inst %h data %h required all 0", if_valid, ls_valid, wr, a, if_inst, ls_dout);
    end
    rst_n = 1'b1; if_pc = 32'h200; c0 = cyc;
    q_if.push_back('{c0 + 6, 1'b1, 32'h1234_5678});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); n = cyc - c0;
      if (n == 1) begin
        vec++;
        if (a !== 32'h200) begin errs++; $display("FAIL after_reset_addr: got %h required 00000200", a); end
      end
      if (if_valid) if_en = 1'b0;
    end
    vec++;
    if (q_if.size() != 0) begin errs++; $display("FAIL after_reset_timeout: %0d pending required 0", q_if.size()); end
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_store();
    test_round_robin();
    test_flush_load();
    test_flush_store();
    test_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
